// File: rtl/tcam_lookup_engine_if.sv
// -----------------------------------------------------------------------------
// tcam_lookup_engine_if
// Purpose : Bundles the command and response valid/ready channels of the TCAM
//           lookup engine into one interface.
// Ports   : none (pure signal bundle)
//   Command channel : cmd_valid, cmd_ready, cmd_op, cmd_addr, cmd_key,
//                     cmd_mask, cmd_data, cmd_vbit
//   Response channel: rsp_valid, rsp_ready, rsp_op, rsp_hit, rsp_multi,
//                     rsp_err, rsp_addr, rsp_key, rsp_mask, rsp_data, rsp_vbit
// Modports: master = requester side (drives commands, consumes responses)
//           slave  = engine side
// -----------------------------------------------------------------------------
interface tcam_lookup_engine_if #(
  parameter int KEY_W = 8,
  parameter int ID_W  = 4,
  parameter int AW    = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [KEY_W-1:0] cmd_key;
  logic [KEY_W-1:0] cmd_mask;
  logic [ID_W-1:0]  cmd_data;
  logic             cmd_vbit;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_op;
  logic             rsp_hit;
  logic             rsp_multi;
  logic             rsp_err;
  logic [AW-1:0]    rsp_addr;
  logic [KEY_W-1:0] rsp_key;
  logic [KEY_W-1:0] rsp_mask;
  logic [ID_W-1:0]  rsp_data;
  logic             rsp_vbit;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_data, cmd_vbit,
    input  cmd_ready,
    input  rsp_valid, rsp_op, rsp_hit, rsp_multi, rsp_err, rsp_addr,
           rsp_key, rsp_mask, rsp_data, rsp_vbit,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_data, cmd_vbit,
    output cmd_ready,
    output rsp_valid, rsp_op, rsp_hit, rsp_multi, rsp_err, rsp_addr,
           rsp_key, rsp_mask, rsp_data, rsp_vbit,
    input  rsp_ready
  );

endinterface

// File: rtl/tcam_lookup_engine.sv
// -----------------------------------------------------------------------------
// tcam_lookup_engine
// Purpose : Behavioural TCAM of DEPTH entries (key, care-mask, data, valid)
//           used for destination-ID lookup. Supports WR, RD, FLUSH and CMP
//           commands; CMP returns the lowest matching index and a multi-hit
//           flag.
// Ports   :
//   clk     in   clock, everything on the rising edge
//   rst     in   synchronous active-high reset
//   bus     slave modport of tcam_lookup_engine_if (command + response
//           valid/ready channels)
//   hit_cnt out  32-bit saturating count of handshaken CMP hits
//                (present only when TCAM_HIT_CNT_EN is defined)
// Configuration macro: TCAM_HIT_CNT_EN
// Latency : WR/RD/FLUSH response valid the cycle after acceptance;
//           CMP spends one cycle in MATCH, response valid the cycle after.
// -----------------------------------------------------------------------------
module tcam_lookup_engine #(
  parameter int KEY_W = 8,
  parameter int ID_W  = 4,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tcam_lookup_engine_if.slave  bus
`ifdef TCAM_HIT_CNT_EN
  ,
  output logic [31:0]          hit_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_WR    = 3'd1;
  localparam logic [2:0] OP_RD    = 3'd2;
  localparam logic [2:0] OP_FLUSH = 3'd3;
  localparam logic [2:0] OP_CMP   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_RSP   = 2'd2
  } state_t;

  // Entry storage. Only the valid bits are reset; contents are don't-care
  // until written and are masked by the valid bit during compare.
  logic [KEY_W-1:0] key_q  [DEPTH];
  logic [KEY_W-1:0] mask_q [DEPTH];
  logic [ID_W-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0] vbit_q;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] search_q;
  logic [DEPTH-1:0] match_d, match_q;

  logic [2:0]       rsp_op_q;
  logic             rsp_err_q;
  logic [AW-1:0]    rsp_addr_q;
  logic [KEY_W-1:0] rsp_key_q;
  logic [KEY_W-1:0] rsp_mask_q;
  logic [ID_W-1:0]  rsp_data_q;
  logic             rsp_vbit_q;

  logic             cmd_fire;
  logic             rsp_fire;
  logic             addr_ok;
  logic             wr_en;
  logic [AW-1:0]    win_idx;
  logic             any_hit;
  logic             multi_hit;
  logic             is_cmp;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RSP);

  assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
  assign rsp_fire = bus.rsp_valid & bus.rsp_ready;
  assign addr_ok  = (int'(bus.cmd_addr) < DEPTH);
  assign wr_en    = cmd_fire & (bus.cmd_op == OP_WR) & addr_ok;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_op == OP_WR || bus.cmd_op == OP_RD || bus.cmd_op == OP_FLUSH) begin
            state_d = ST_RSP;
          end else if (bus.cmd_op == OP_CMP) begin
            state_d = ST_MATCH;
          end
          // NOP and reserved ops are consumed without a response.
        end
      end
      ST_MATCH: state_d = ST_RSP;
      ST_RSP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-entry match against the latched search key
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_d[gi] = vbit_q[gi] & (((key_q[gi] ^ search_q) & mask_q[gi]) == '0);
    end
  endgenerate

  // Lowest index wins: scan downwards so the last assignment is the lowest hit.
  always_comb begin
    win_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        win_idx = AW'(i);
      end
    end
  end

  assign any_hit   = |match_q;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hit = |(match_q & (match_q - DEPTH'(1)));

  // ---------------------------------------------------------------------------
  // Entry contents (no reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      key_q[bus.cmd_addr]  <= bus.cmd_key;
      mask_q[bus.cmd_addr] <= bus.cmd_mask;
      data_q[bus.cmd_addr] <= bus.cmd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // State, valid bits and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vbit_q     <= '0;
      search_q   <= '0;
      match_q    <= '0;
      rsp_op_q   <= '0;
      rsp_err_q  <= 1'b0;
      rsp_addr_q <= '0;
      rsp_key_q  <= '0;
      rsp_mask_q <= '0;
      rsp_data_q <= '0;
      rsp_vbit_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (cmd_fire) begin
        case (bus.cmd_op)
          OP_WR: begin
            rsp_op_q   <= OP_WR;
            rsp_addr_q <= bus.cmd_addr;
            rsp_err_q  <= !addr_ok;
            if (addr_ok) begin
              vbit_q[bus.cmd_addr] <= bus.cmd_vbit;
            end
          end
          OP_RD: begin
            rsp_op_q   <= OP_RD;
            rsp_addr_q <= bus.cmd_addr;
            rsp_err_q  <= !addr_ok;
            if (addr_ok) begin
              rsp_key_q  <= key_q[bus.cmd_addr];
              rsp_mask_q <= mask_q[bus.cmd_addr];
              rsp_data_q <= data_q[bus.cmd_addr];
              rsp_vbit_q <= vbit_q[bus.cmd_addr];
            end
          end
          OP_FLUSH: begin
            rsp_op_q <= OP_FLUSH;
            vbit_q   <= '0;
          end
          OP_CMP: begin
            rsp_op_q <= OP_CMP;
            search_q <= bus.cmd_key;
          end
          default: ;
        endcase
      end

      if (state_q == ST_MATCH) begin
        match_q <= match_d;
      end

      // Return every response field to zero once consumed so fields that an
      // op does not define read as 0 on the next response.
      if (rsp_fire) begin
        match_q    <= '0;
        rsp_op_q   <= '0;
        rsp_err_q  <= 1'b0;
        rsp_addr_q <= '0;
        rsp_key_q  <= '0;
        rsp_mask_q <= '0;
        rsp_data_q <= '0;
        rsp_vbit_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response outputs. CMP results are encoded from the registered match
  // vector; nothing can write the array while a response is pending, so the
  // encoded fields stay stable under back-pressure.
  // ---------------------------------------------------------------------------
  assign is_cmp = (state_q == ST_RSP) && (rsp_op_q == OP_CMP);

  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_hit   = is_cmp & any_hit;
  assign bus.rsp_multi = is_cmp & multi_hit;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_addr  = is_cmp ? win_idx : rsp_addr_q;
  assign bus.rsp_key   = rsp_key_q;
  assign bus.rsp_mask  = rsp_mask_q;
  assign bus.rsp_data  = is_cmp ? (any_hit ? data_q[win_idx] : '0) : rsp_data_q;
  assign bus.rsp_vbit  = rsp_vbit_q;

`ifdef TCAM_HIT_CNT_EN
  logic [31:0] hit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
    end else if (cmd_fire && bus.cmd_op == OP_FLUSH) begin
      hit_cnt_q <= '0;
    end else if (rsp_fire && is_cmp && any_hit && hit_cnt_q != 32'hFFFF_FFFF) begin
      hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_tcam_lookup_engine.sv
// -----------------------------------------------------------------------------
// tb_tcam_lookup_engine
// Purpose : Self-checking bench for tcam_lookup_engine. A 16-entry instance is
//           exercised with directed and random commands against a behavioural
//           table model; a 12-entry instance covers out-of-range addressing.
// Optional: build with TCAM_HIT_CNT_EN to also check hit_cnt.
// -----------------------------------------------------------------------------
module tb_tcam_lookup_engine;

  localparam logic [2:0] OP_NOP = 3'd0, OP_WR = 3'd1, OP_RD = 3'd2,
                         OP_FLUSH = 3'd3, OP_CMP = 3'd4;

  typedef struct packed {
    logic [2:0] op;
    logic       hit;
    logic       multi;
    logic       err;
    logic [3:0] addr;
    logic [7:0] key;
    logic [7:0] mask;
    logic [3:0] data;
    logic       vbit;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcam_lookup_engine_if #(.KEY_W(8), .ID_W(4), .AW(4)) ifc ();
  tcam_lookup_engine_if #(.KEY_W(8), .ID_W(4), .AW(4)) ifc12 ();

`ifdef TCAM_HIT_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] hit_cnt12;
`endif

  tcam_lookup_engine #(.KEY_W(8), .ID_W(4), .DEPTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifc)
`ifdef TCAM_HIT_CNT_EN
    ,
    .hit_cnt (hit_cnt)
`endif
  );

  tcam_lookup_engine #(.KEY_W(8), .ID_W(4), .DEPTH(12)) dut12 (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifc12)
`ifdef TCAM_HIT_CNT_EN
    ,
    .hit_cnt (hit_cnt12)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Behavioural table model of the 16-entry instance.
  logic [7:0]  m_key  [16];
  logic [7:0]  m_mask [16];
  logic [3:0]  m_data [16];
  logic        m_vbit [16];
  int unsigned m_hits = 0;

  // Apply one command to the model and return the response it must produce.
  function automatic rsp_t model_exec(input logic [2:0] op, input logic [3:0] addr,
                                      input logic [7:0] key, input logic [7:0] mask,
                                      input logic [3:0] data, input logic vbit);
    rsp_t e;
    int   n;
    e = '0;
    e.op = op;
    case (op)
      OP_WR: begin
        e.addr = addr;
        m_key[addr] = key; m_mask[addr] = mask; m_data[addr] = data; m_vbit[addr] = vbit;
      end
      OP_RD: begin
        e.addr = addr; e.key = m_key[addr]; e.mask = m_mask[addr];
        e.data = m_data[addr]; e.vbit = m_vbit[addr];
      end
      OP_FLUSH: begin
        for (int i = 0; i < 16; i++) m_vbit[i] = 1'b0;
        m_hits = 0;
      end
      OP_CMP: begin
        n = 0;
        for (int i = 0; i < 16; i++) begin
          if (m_vbit[i] && (((m_key[i] ^ key) & m_mask[i]) == 8'h00)) begin
            if (n == 0) begin
              e.addr = 4'(i);
              e.data = m_data[i];
            end
            n++;
          end
        end
        e.hit   = (n > 0);
        e.multi = (n > 1);
        if (e.hit && m_hits != 32'hFFFF_FFFF) m_hits++;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic rsp_t get_rsp(input bit s12);
    rsp_t r;
    if (s12) begin
      r.op = ifc12.rsp_op; r.hit = ifc12.rsp_hit; r.multi = ifc12.rsp_multi;
      r.err = ifc12.rsp_err; r.addr = ifc12.rsp_addr; r.key = ifc12.rsp_key;
      r.mask = ifc12.rsp_mask; r.data = ifc12.rsp_data; r.vbit = ifc12.rsp_vbit;
    end else begin
      r.op = ifc.rsp_op; r.hit = ifc.rsp_hit; r.multi = ifc.rsp_multi;
      r.err = ifc.rsp_err; r.addr = ifc.rsp_addr; r.key = ifc.rsp_key;
      r.mask = ifc.rsp_mask; r.data = ifc.rsp_data; r.vbit = ifc.rsp_vbit;
    end
    return r;
  endfunction

  // Present a command and return 1ns after the accepting edge.
  task automatic issue(input bit s12, input logic [2:0] op, input logic [3:0] addr,
                       input logic [7:0] key, input logic [7:0] mask,
                       input logic [3:0] data, input logic vbit);
    int n;
    logic rdy;
    @(negedge clk);
    if (s12) begin
      ifc12.cmd_op = op; ifc12.cmd_addr = addr; ifc12.cmd_key = key;
      ifc12.cmd_mask = mask; ifc12.cmd_data = data; ifc12.cmd_vbit = vbit;
      ifc12.cmd_valid = 1'b1;
    end else begin
      ifc.cmd_op = op; ifc.cmd_addr = addr; ifc.cmd_key = key;
      ifc.cmd_mask = mask; ifc.cmd_data = data; ifc.cmd_vbit = vbit;
      ifc.cmd_valid = 1'b1;
    end
    n = 0;
    rdy = s12 ? ifc12.cmd_ready : ifc.cmd_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = s12 ? ifc12.cmd_ready : ifc.cmd_ready;
    end
    if (!rdy) begin
      tests++; fails++;
      $display("FAIL cmd_accept_timeout cmd_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    if (s12) ifc12.cmd_valid = 1'b0; else ifc.cmd_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until rsp_valid is seen (99 = never).
  task automatic wait_rsp(input bit s12, output int lat);
    logic v;
    lat = 1;
    @(negedge clk);
    v = s12 ? ifc12.rsp_valid : ifc.rsp_valid;
    while (!v && lat < 20) begin
      @(negedge clk);
      lat++;
      v = s12 ? ifc12.rsp_valid : ifc.rsp_valid;
    end
    if (!v) lat = 99;
  endtask

  task automatic do_op(input bit s12, input logic [2:0] op, input logic [3:0] addr,
                       input logic [7:0] key, input logic [7:0] mask,
                       input logic [3:0] data, input logic vbit,
                       output rsp_t r, output int lat);
    logic rr;
    issue(s12, op, addr, key, mask, data, vbit);
    wait_rsp(s12, lat);
    r = get_rsp(s12);
    $display("[TB] dut%0d op=%0d addr=%0d key=%h mask=%h data=%h vbit=%0d -> lat=%0d rsp=%h",
             s12 ? 12 : 16, op, addr, key, mask, data, vbit, lat, r);
    rr = s12 ? ifc12.rsp_ready : ifc.rsp_ready;
    if (rr && lat != 99) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rsp_t r;
    int   lat;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (ifc.cmd_ready !== 1'b1 || ifc.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshake cmd_ready=%b rsp_valid=%b, required 1 0", ifc.cmd_ready, ifc.rsp_valid);
    end
    tests++;
    if (get_rsp(1'b0) !== rsp_t'(0)) begin
      fails++;
      $display("FAIL reset_rsp_fields got=%h, required 0", get_rsp(1'b0));
    end
`ifdef TCAM_HIT_CNT_EN
    tests++;
    if (hit_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_hit_cnt got=%0d, required 0", hit_cnt);
    end
`endif
    do_op(1'b0, OP_RD, 4'd3, 8'h00, 8'h00, 4'h0, 1'b0, r, lat);
    tests++;
    if (lat != 1 || r.vbit !== 1'b0 || r.err !== 1'b0 || r.op !== OP_RD || r.addr !== 4'd3) begin
      fails++;
      $display("FAIL reset_rd_a3 lat=%0d vbit=%b err=%b op=%0d addr=%0d, required 1 0 0 2 3",
               lat, r.vbit, r.err, r.op, r.addr);
    end
  endtask

  task automatic test_write_compare();
    rsp_t r, e;
    int   lat;
    logic [2:0]  ops  [6] = '{OP_WR, OP_CMP, OP_WR, OP_CMP, OP_CMP, OP_RD};
    logic [3:0]  adrs [6] = '{4'd5, 4'd0, 4'd2, 4'd0, 4'd0, 4'd5};
    logic [7:0]  keys [6] = '{8'hA0, 8'hA3, 8'hA3, 8'hA3, 8'hB3, 8'h00};
    logic [7:0]  msks [6] = '{8'hF0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    logic [3:0]  dats [6] = '{4'h7, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 6; i++) begin
      e = model_exec(ops[i], adrs[i], keys[i], msks[i], dats[i], 1'b1);
      do_op(1'b0, ops[i], adrs[i], keys[i], msks[i], dats[i], 1'b1, r, lat);
      tests++;
      if (r !== e || lat != ((ops[i] == OP_CMP) ? 2 : 1)) begin
        fails++;
        $display("FAIL directed_%0d op=%0d got=%h lat=%0d, required %h lat=%0d",
                 i, ops[i], r, lat, e, (ops[i] == OP_CMP) ? 2 : 1);
      end
    end
  endtask

  task automatic test_nop();
    logic [2:0] nops [2] = '{OP_NOP, 3'd6};
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, nops[i], 4'd1, 8'hA3, 8'hFF, 4'h1, 1'b1);
      $display("[TB] dut16 op=%0d dropped", nops[i]);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        tests++;
        if (ifc.rsp_valid !== 1'b0 || ifc.cmd_ready !== 1'b1) begin
          fails++;
          $display("FAIL nop_no_rsp op=%0d cyc=%0d rsp_valid=%b cmd_ready=%b, required 0 1",
                   nops[i], c, ifc.rsp_valid, ifc.cmd_ready);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t r, r0, e;
    int   lat;
    ifc.rsp_ready = 1'b0;
    e = model_exec(OP_CMP, 4'd0, 8'hA3, 8'h00, 4'h0, 1'b0);
    do_op(1'b0, OP_CMP, 4'd0, 8'hA3, 8'h00, 4'h0, 1'b0, r0, lat);
    tests++;
    if (r0 !== e || lat != 2) begin
      fails++;
      $display("FAIL bp_first got=%h lat=%0d, required %h lat=2", r0, lat, e);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      r = get_rsp(1'b0);
      tests++;
      if (r !== r0 || ifc.rsp_valid !== 1'b1 || ifc.cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d rsp=%h valid=%b ready=%b, required %h 1 0",
                 c, r, ifc.rsp_valid, ifc.cmd_ready, r0);
      end
    end
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (ifc.rsp_valid !== 1'b0 || ifc.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release rsp_valid=%b cmd_ready=%b, required 0 1", ifc.rsp_valid, ifc.cmd_ready);
    end
  endtask

  task automatic test_flush_hitcnt();
    rsp_t r, e;
    int   lat;
    e = model_exec(OP_FLUSH, 4'd0, 8'h00, 8'h00, 4'h0, 1'b0);
    do_op(1'b0, OP_FLUSH, 4'd0, 8'h00, 8'h00, 4'h0, 1'b0, r, lat);
    tests++;
    if (r !== e || lat != 1) begin
      fails++;
      $display("FAIL flush_rsp got=%h lat=%0d, required %h lat=1", r, lat, e);
    end
`ifdef TCAM_HIT_CNT_EN
    tests++;
    if (hit_cnt !== 32'd0) begin
      fails++;
      $display("FAIL flush_hit_cnt got=%0d, required 0", hit_cnt);
    end
`endif
    e = model_exec(OP_CMP, 4'd0, 8'hA3, 8'h00, 4'h0, 1'b0);
    do_op(1'b0, OP_CMP, 4'd0, 8'hA3, 8'h00, 4'h0, 1'b0, r, lat);
    tests++;
    if (r !== e || r.hit !== 1'b0) begin
      fails++;
      $display("FAIL flush_cmp_miss got=%h, required %h", r, e);
    end
    e = model_exec(OP_WR, 4'd9, 8'h3C, 8'h00, 4'hE, 1'b1);
    do_op(1'b0, OP_WR, 4'd9, 8'h3C, 8'h00, 4'hE, 1'b1, r, lat);
    for (int i = 0; i < 3; i++) begin
      e = model_exec(OP_CMP, 4'd0, 8'(i * 37), 8'h00, 4'h0, 1'b0);
      do_op(1'b0, OP_CMP, 4'd0, 8'(i * 37), 8'h00, 4'h0, 1'b0, r, lat);
      tests++;
      if (r !== e) begin
        fails++;
        $display("FAIL hit_cmp_%0d got=%h, required %h", i, r, e);
      end
    end
`ifdef TCAM_HIT_CNT_EN
    tests++;
    if (hit_cnt !== 32'(m_hits) || m_hits != 3) begin
      fails++;
      $display("FAIL hit_cnt_three got=%0d, required %0d (3)", hit_cnt, m_hits);
    end
`endif
  endtask

  task automatic test_random();
    rsp_t r, e;
    int   lat, sel;
    logic [2:0] op;
    logic [3:0] addr, data;
    logic [7:0] key, mask;
    logic       vb;
    logic [7:0] mtab [5] = '{8'hFF, 8'hF0, 8'h0F, 8'h00, 8'hFC};
    for (int n = 0; n < 76; n++) begin
      if (n < 16) begin
        op = OP_WR; addr = 4'(n);
      end else begin
        sel  = int'($urandom_range(0, 9));
        op   = (sel < 3) ? OP_WR : (sel < 5) ? OP_RD : (sel == 5) ? OP_FLUSH : OP_CMP;
        addr = 4'($urandom_range(0, 15));
      end
      key  = {4'hA, 2'b00, 2'($urandom_range(0, 3))};
      mask = mtab[$urandom_range(0, 4)];
      data = 4'($urandom);
      vb   = ($urandom_range(0, 4) != 0);
      e = model_exec(op, addr, key, mask, data, vb);
      do_op(1'b0, op, addr, key, mask, data, vb, r, lat);
      tests++;
      if (r !== e || lat != ((op == OP_CMP) ? 2 : 1)) begin
        fails++;
        $display("FAIL random_%0d op=%0d got=%h lat=%0d, required %h", n, op, r, lat, e);
      end
    end
`ifdef TCAM_HIT_CNT_EN
    tests++;
    if (hit_cnt !== 32'(m_hits)) begin
      fails++;
      $display("FAIL random_hit_cnt got=%0d, required %0d", hit_cnt, m_hits);
    end
`endif
  endtask

  task automatic test_reset_mid();
    rsp_t r, e;
    int   lat;
    e = model_exec(OP_WR, 4'd5, 8'hA0, 8'hF0, 4'h7, 1'b1);
    do_op(1'b0, OP_WR, 4'd5, 8'hA0, 8'hF0, 4'h7, 1'b1, r, lat);
    issue(1'b0, OP_CMP, 4'd0, 8'hA3, 8'h00, 4'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_vbit[i] = 1'b0;
    m_hits = 0;
    $display("[TB] dut16 reset during MATCH");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if (ifc.rsp_valid !== 1'b0 || ifc.cmd_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_mid cyc=%0d rsp_valid=%b cmd_ready=%b, required 0 1",
                 c, ifc.rsp_valid, ifc.cmd_ready);
      end
    end
    e = model_exec(OP_RD, 4'd5, 8'h00, 8'h00, 4'h0, 1'b0);
    do_op(1'b0, OP_RD, 4'd5, 8'h00, 8'h00, 4'h0, 1'b0, r, lat);
    tests++;
    if (r !== e || r.vbit !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_rd_a5 got=%h, required %h", r, e);
    end
  endtask

  task automatic test_depth12();
    rsp_t r, e;
    int   lat;
    do_op(1'b1, OP_WR, 4'd3, 8'h5A, 8'hFF, 4'h9, 1'b1, r, lat);
    e = '0; e.op = OP_WR; e.addr = 4'd3;
    tests++;
    if (r !== e || lat != 1) begin
      fails++;
      $display("FAIL d12_wr_a3 got=%h lat=%0d, required %h lat=1", r, lat, e);
    end
    do_op(1'b1, OP_WR, 4'd13, 8'h5A, 8'h00, 4'h4, 1'b1, r, lat);
    e = '0; e.op = OP_WR; e.addr = 4'd13; e.err = 1'b1;
    tests++;
    if (r !== e || lat != 1) begin
      fails++;
      $display("FAIL d12_wr_a13 got=%h lat=%0d, required %h lat=1", r, lat, e);
    end
    do_op(1'b1, OP_RD, 4'd13, 8'h00, 8'h00, 4'h0, 1'b0, r, lat);
    e = '0; e.op = OP_RD; e.addr = 4'd13; e.err = 1'b1;
    tests++;
    if (r !== e) begin
      fails++;
      $display("FAIL d12_rd_a13 got=%h, required %h", r, e);
    end
    do_op(1'b1, OP_CMP, 4'd0, 8'h5A, 8'h00, 4'h0, 1'b0, r, lat);
    e = '0; e.op = OP_CMP; e.hit = 1'b1; e.addr = 4'd3; e.data = 4'h9;
    tests++;
    if (r !== e || lat != 2) begin
      fails++;
      $display("FAIL d12_cmp_hit got=%h lat=%0d, required %h lat=2", r, lat, e);
    end
    do_op(1'b1, OP_CMP, 4'd0, 8'h00, 8'h00, 4'h0, 1'b0, r, lat);
    e = '0; e.op = OP_CMP;
    tests++;
    if (r !== e) begin
      fails++;
      $display("FAIL d12_cmp_miss got=%h, required %h", r, e);
    end
  endtask

  initial begin
    ifc.cmd_valid = 1'b0; ifc.cmd_op = '0; ifc.cmd_addr = '0; ifc.cmd_key = '0;
    ifc.cmd_mask = '0; ifc.cmd_data = '0; ifc.cmd_vbit = 1'b0; ifc.rsp_ready = 1'b1;
    ifc12.cmd_valid = 1'b0; ifc12.cmd_op = '0; ifc12.cmd_addr = '0; ifc12.cmd_key = '0;
    ifc12.cmd_mask = '0; ifc12.cmd_data = '0; ifc12.cmd_vbit = 1'b0; ifc12.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_key[i] = '0; m_mask[i] = '0; m_data[i] = '0; m_vbit[i] = 1'b0;
    end

    test_reset();
    test_write_compare();
    test_nop();
    test_backpressure();
    test_flush_hitcnt();
    test_random();
    test_reset_mid();
    test_depth12();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
